// File: rtl/top_lvl_pkg.sv
// Shared constants for the top_lvl FIFO: default word width, address width and depth.
package top_lvl_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DEPTH_DEF      = 2 ** ADDR_WIDTH_DEF;
endpackage

// File: rtl/top_lvl_fifo_mem.sv
// fifo_mem: DEPTH x DATA_WIDTH storage, one synchronous write port and one registered read port.
module fifo_mem
  import top_lvl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // No reset so the array maps onto block RAM; a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/top_lvl.sv
// top_lvl: synchronous FIFO with registered read data, occupancy count and full/empty flags.
// Optional sticky overflow/underflow outputs are enabled by defining TOP_LVL_ERR_FLAGS_EN.
module top_lvl
  import top_lvl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic                  full,
  output logic                  empty,
`ifdef TOP_LVL_ERR_FLAGS_EN
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  overflow,
  output logic                  underflow
`else
  output logic [ADDR_WIDTH:0]   usedw
`endif
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   usedw_next;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  out_clear;
  logic                  rd_accept;
  logic                  wr_accept;

  assign rd_accept = rdreq & ~empty;
  // A write into a full FIFO is allowed only when a read frees a slot on the same edge.
  assign wr_accept = rst & wrreq & (~full | rd_accept);

  always_comb begin
    usedw_next = usedw;
    case ({wr_accept, rd_accept})
      2'b10:   usedw_next = usedw + (ADDR_WIDTH + 1)'(1);
      2'b01:   usedw_next = usedw - (ADDR_WIDTH + 1)'(1);
      default: usedw_next = usedw;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      usedw     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      out_clear <= 1'b1;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_accept) begin
        rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
        out_clear <= 1'b0;
      end
      usedw <= usedw_next;
      empty <= (usedw_next == '0);
      full  <= (usedw_next == (ADDR_WIDTH + 1)'(DEPTH));
    end
  end

  // The RAM read register has no reset, so data_out is forced to zero until the first read after reset.
  assign data_out = out_clear ? '0 : rd_data;

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_accept),
    .wr_addr(wr_ptr),
    .wr_data(data_in),
    .rd_en  (rd_accept),
    .rd_addr(rd_ptr),
    .rd_data(rd_data)
  );

`ifdef TOP_LVL_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wrreq & ~wr_accept) overflow  <= 1'b1;
      if (rdreq & empty)      underflow <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_top_lvl.sv
// Self-checking bench for top_lvl: directed fill/drain/stream/wrap/mid-reset scenarios plus
// randomized traffic checked against a queue-based FIFO model.
module tb_top_lvl;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          wrreq = 1'b0;
  logic          rdreq = 1'b0;
  wire  [DW-1:0] data_out;
  wire           full;
  wire           empty;
  wire  [AW:0]   usedw;
`ifdef TOP_LVL_ERR_FLAGS_EN
  wire           overflow;
  wire           underflow;
`endif

  top_lvl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (data_out),
    .wrreq    (wrreq),
    .rdreq    (rdreq),
    .full     (full),
    .empty    (empty),
`ifdef TOP_LVL_ERR_FLAGS_EN
    .usedw    (usedw),
    .overflow (overflow),
    .underflow(underflow)
`else
    .usedw    (usedw)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: an ideal FIFO as a queue, plus the last word read out.
  logic [DW-1:0] q[$];
  logic [DW-1:0] dout_m;
  bit            ovf_m;
  bit            udf_m;

  task automatic model_reset();
    q.delete();
    dout_m = '0;
    ovf_m  = 1'b0;
    udf_m  = 1'b0;
  endtask

  // Drive one clock cycle of stimulus and advance the model; checks live in the test tasks.
  task automatic step(input bit w, input bit r, input logic [DW-1:0] d);
    bit ra;
    bit wa;
    wrreq   = w;
    rdreq   = r;
    data_in = d;
    @(posedge clk);
    #1;
    ra = r && (q.size() != 0);
    wa = w && ((q.size() < DEPTH) || ra);
    if (r && !ra) udf_m = 1'b1;
    if (w && !wa) ovf_m = 1'b1;
    if (ra) dout_m = q.pop_front();
    if (wa) q.push_back(d);
    $display("txn t=%0t wr=%0b rd=%0b din=%0d -> dout=%0d usedw=%0d full=%0b empty=%0b",
             $time, w, r, d, data_out, usedw, full, empty);
    wrreq = 1'b0;
    rdreq = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #12;
    n_cmp += 4;
    if (usedw !== 5'd0)  begin n_bad++; $display("FAIL reset_usedw: got %0d expected 0", usedw); end
    if (empty !== 1'b1)  begin n_bad++; $display("FAIL reset_empty: got %0b expected 1", empty); end
    if (full !== 1'b0)   begin n_bad++; $display("FAIL reset_full: got %0b expected 0", full); end
    if (data_out !== '0) begin n_bad++; $display("FAIL reset_dout: got %0d expected 0", data_out); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b0, DW'(i));
      n_cmp++;
      if (usedw !== (AW+1)'(i)) begin n_bad++; $display("FAIL fill_usedw[%0d]: got %0d expected %0d", i, usedw, i); end
    end
    n_cmp += 2;
    if (full !== 1'b1)  begin n_bad++; $display("FAIL fill_full: got %0b expected 1", full); end
    if (empty !== 1'b0) begin n_bad++; $display("FAIL fill_empty: got %0b expected 0", empty); end
    step(1'b1, 1'b0, 8'd99);
    n_cmp += 2;
    if (usedw !== 5'd16) begin n_bad++; $display("FAIL fill_extra_usedw: got %0d expected 16", usedw); end
    if (full !== 1'b1)   begin n_bad++; $display("FAIL fill_extra_full: got %0b expected 1", full); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1, '0);
      n_cmp++;
      if (data_out !== DW'(i)) begin n_bad++; $display("FAIL drain_dout[%0d]: got %0d expected %0d", i, data_out, i); end
    end
    n_cmp += 2;
    if (empty !== 1'b1)  begin n_bad++; $display("FAIL drain_empty: got %0b expected 1", empty); end
    if (usedw !== 5'd0)  begin n_bad++; $display("FAIL drain_usedw: got %0d expected 0", usedw); end
    step(1'b0, 1'b1, '0);
    n_cmp += 2;
    if (data_out !== 8'd16) begin n_bad++; $display("FAIL drain_extra_dout: got %0d expected 16", data_out); end
    if (usedw !== 5'd0)     begin n_bad++; $display("FAIL drain_extra_usedw: got %0d expected 0", usedw); end
  endtask

  task automatic test_stream();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #2;
    rst = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b1, DW'(i));
      n_cmp += 2;
      if (usedw !== 5'd1) begin n_bad++; $display("FAIL stream_usedw[%0d]: got %0d expected 1", i, usedw); end
      if (data_out !== DW'(i - 1)) begin
        n_bad++; $display("FAIL stream_dout[%0d]: got %0d expected %0d", i, data_out, i - 1);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k <= 10; k++) step(1'b1, 1'b0, DW'(r * 10 + k));
      for (int k = 1; k <= 10; k++) begin
        step(1'b0, 1'b1, '0);
        n_cmp++;
        if (data_out !== DW'(r * 10 + k)) begin
          n_bad++; $display("FAIL wrap_dout[%0d]: got %0d expected %0d", r * 10 + k, data_out, r * 10 + k);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, DW'(40 + i));
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    // Pulse reset between edges and look before the next rising edge.
    rst = 1'b0;
    model_reset();
    #2;
    n_cmp += 4;
    if (empty !== 1'b1)  begin n_bad++; $display("FAIL midrst_empty: got %0b expected 1", empty); end
    if (usedw !== 5'd0)  begin n_bad++; $display("FAIL midrst_usedw: got %0d expected 0", usedw); end
    if (full !== 1'b0)   begin n_bad++; $display("FAIL midrst_full: got %0b expected 0", full); end
    if (data_out !== '0) begin n_bad++; $display("FAIL midrst_dout: got %0d expected 0", data_out); end
    rst = 1'b1;
    step(1'b1, 1'b0, 8'd77);
    step(1'b0, 1'b1, '0);
    n_cmp += 2;
    if (data_out !== 8'd77) begin n_bad++; $display("FAIL midrst_new_dout: got %0d expected 77", data_out); end
    if (empty !== 1'b1)     begin n_bad++; $display("FAIL midrst_new_empty: got %0b expected 1", empty); end
  endtask

  task automatic test_random();
    int pw;
    int pr;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      pw = ((c / 50) % 2 == 0) ? 80 : 25;
      pr = ((c / 50) % 2 == 0) ? 30 : 80;
      step($urandom_range(99) < pw, $urandom_range(99) < pr, DW'($urandom));
      n_cmp += 4;
      if (data_out !== dout_m) begin n_bad++; $display("FAIL rand_dout[%0d]: got %0d expected %0d", c, data_out, dout_m); end
      if (usedw !== (AW+1)'(q.size())) begin n_bad++; $display("FAIL rand_usedw[%0d]: got %0d expected %0d", c, usedw, q.size()); end
      if (full !== (q.size() == DEPTH)) begin n_bad++; $display("FAIL rand_full[%0d]: got %0b expected %0b", c, full, q.size() == DEPTH); end
      if (empty !== (q.size() == 0)) begin n_bad++; $display("FAIL rand_empty[%0d]: got %0b expected %0b", c, empty, q.size() == 0); end
`ifdef TOP_LVL_ERR_FLAGS_EN
      n_cmp += 2;
      if (overflow !== ovf_m)  begin n_bad++; $display("FAIL rand_ovf[%0d]: got %0b expected %0b", c, overflow, ovf_m); end
      if (underflow !== udf_m) begin n_bad++; $display("FAIL rand_udf[%0d]: got %0b expected %0b", c, underflow, udf_m); end
`endif
    end
  endtask

`ifdef TOP_LVL_ERR_FLAGS_EN
  task automatic test_err_flags();
    do_reset();
    n_cmp += 2;
    if (overflow !== 1'b0)  begin n_bad++; $display("FAIL err_ovf_rst: got %0b expected 0", overflow); end
    if (underflow !== 1'b0) begin n_bad++; $display("FAIL err_udf_rst: got %0b expected 0", underflow); end
    step(1'b0, 1'b1, '0);
    n_cmp += 2;
    if (underflow !== 1'b1) begin n_bad++; $display("FAIL err_udf_set: got %0b expected 1", underflow); end
    if (overflow !== 1'b0)  begin n_bad++; $display("FAIL err_ovf_clear: got %0b expected 0", overflow); end
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i));
    step(1'b1, 1'b0, 8'd5);
    step(1'b0, 1'b1, '0);
    n_cmp += 2;
    if (overflow !== 1'b1)  begin n_bad++; $display("FAIL err_ovf_set: got %0b expected 1", overflow); end
    if (underflow !== 1'b1) begin n_bad++; $display("FAIL err_udf_sticky: got %0b expected 1", underflow); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_wrap();
    test_mid_reset();
    test_random();
`ifdef TOP_LVL_ERR_FLAGS_EN
    test_err_flags();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
